riscv_crypto_fu_issue: RTL and testbench
========================================

# riscv_crypto_fu_issue

Request-side sequencer that drives a crypto functional unit (xperm, and any other unit sharing the valid/ready/op/rs1/rs2/rd contract). Accepts one decoded operation at a time from the pipeline and holds the operands stable on the FU port until the FU returns `ready`. It captures `rd` and presents it on a writeback handshake, with timeout, illegal-op and flush handling. It sits between the decode/issue stage and the FU instances.

## Interface
- `XLEN`, 64: operand width; must be 32 or 64.
- `OPW`, 2: width of the one-hot op vector; bit 0 = xperm4, bit 1 = xperm8.
- `TIMEOUT`, 16: maximum number of cycles with `fu_valid` high before an error is reported; must be ≥2.

Ports:
- `g_clk` in 1: global clock.
- `g_reset` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous abort of any in-flight operation.
- `req_valid` in 1 / `req_ready` out 1: upstream handshake.
- `req_op` in OPW: one-hot operation select.
- `req_rs1` in XLEN: source 1.
- `req_rs2` in XLEN: source 2.
- `req_rd_addr` in 5: destination register tag.
- `fu_valid` out 1, `fu_op` out OPW, `fu_rs1` out XLEN, `fu_rs2` out XLEN: FU request, all registered.
- `fu_ready` in 1, `fu_rd` in XLEN: FU response.
- `wb_valid` out 1 / `wb_ready` in 1: writeback handshake.
- `wb_data` out XLEN: result.
- `wb_rd_addr` out 5: destination register tag.
- `wb_err` out 1: set on timeout or illegal op.

## Operation
- There are three states: IDLE, ISSUE and RESP. The reset state is IDLE.
- **IDLE**
  - `req_ready=1`.
  - On `req_valid`, latch op, rs1, rs2 and rd_addr, and clear the cycle counter.
  - If `req_op` is one-hot, go to ISSUE.
  - Otherwise (zero bits or multiple bits set), go directly to RESP with `wb_err=1`, `wb_data=0`. The FU is never driven in this case.
- **ISSUE**
  - `fu_valid=1`. `fu_op`, `fu_rs1` and `fu_rs2` hold the latched values unchanged.
  - When `fu_ready=1`, capture `fu_rd` into `wb_data`, set `wb_err=0`, and go to RESP.
  - Otherwise, increment the counter. When the counter reaches `TIMEOUT-1` without `fu_ready`, go to RESP with `wb_err=1`, `wb_data=0`.
  - If `fu_ready` arrives in the same cycle the timeout would fire, `fu_ready` wins.
- **RESP**
  - `wb_valid=1`. `wb_data`, `wb_err` and `wb_rd_addr` are held stable until `wb_ready`.
  - On `wb_ready`, go to IDLE.
  - `req_ready = wb_ready` in RESP. A simultaneous `req_valid` is accepted in that cycle and follows the IDLE rules, so the next state is ISSUE (or RESP for an illegal op). This gives back-to-back issue.
- **Flush**
  - Highest priority after reset.
  - Next state is IDLE, and `fu_valid`/`wb_valid` are deasserted the next cycle.
  - The pending result is discarded. `req_ready=0` in the flush cycle, so no request is accepted.
- **Counter**
  - Width is clog2(TIMEOUT). It saturates and never wraps; it only counts in ISSUE.
- **fu_op**
  - Driven to 0 outside ISSUE, so downstream FU muxes see no op.

## Timing
- **Reset values**: while `g_reset` is high and on the first cycle after it:
  - `req_ready=0` during reset, then 1 in IDLE.
  - `fu_valid=0`, `fu_op=0`, `fu_rs1=0`, `fu_rs2=0`.
  - `wb_valid=0`, `wb_data=0`, `wb_rd_addr=0`, `wb_err=0`.
- Reset mid-operation behaves like flush: the operation is dropped and no writeback is produced.
- **Latency** for a single-cycle FU (`ready=valid`): request accepted at edge N, `fu_valid` high in cycle N+1, `wb_valid` high in cycle N+2. Minimum request-to-writeback latency is 2 cycles.
- **Back-to-back throughput**: one op per 2 cycles when `wb_ready` is tied high.
- **Illegal op**: `wb_valid` is high in cycle N+1.
- **Timeout**: `fu_valid` is high for exactly `TIMEOUT` cycles, then `wb_valid` rises the following cycle.
- `fu_*` outputs never change while `fu_valid=1` and `fu_ready=0`. `wb_*` outputs never change while `wb_valid=1` and `wb_ready=0`.

## Test plan
- **Single xperm8 op.** Inputs: XLEN=64, `rs2=0x0706050403020100`, `rs1=0x0001020304050607`, `op=2'b10`, `rd_addr=5`, FU ready=valid, `wb_ready=1`.
  - Expect `fu_valid` for 1 cycle, then `wb_valid` with `wb_data=0x0001020304050607`, `wb_rd_addr=5`, `wb_err=0`, 2 cycles after accept.
- **Writeback backpressure.** Hold `wb_ready=0` for 5 cycles in RESP.
  - Expect `wb_*` stable and `req_ready=0`.
  - Then assert `wb_ready` together with a new `req_valid`: that request is accepted and the next state is ISSUE.
- **Timeout.** TIMEOUT=4, `fu_ready` tied low.
  - Expect `fu_valid` high exactly 4 cycles, then `wb_valid` with `wb_err=1`, `wb_data=0`.
  - Repeat with `fu_ready` asserted on the 4th cycle: expect `wb_err=0` and the FU data captured.
- **Illegal op.** `req_op=2'b11`, then `req_op=2'b00`.
  - Expect `fu_valid` never asserted, and `wb_valid` with `wb_err=1` one cycle after each accept.
- **Flush.** Assert `flush` in ISSUE and separately in RESP.
  - Expect `fu_valid`/`wb_valid` low next cycle, no writeback for the flushed op, and `req_ready=1` the cycle after.
- **Reset mid-ISSUE.** Assert `g_reset` for 1 cycle while in ISSUE.
  - Expect all outputs at their reset values and no writeback.
  - A subsequent xperm4 op (XLEN=32) completes normally.

Source files
------------

// File: rtl/riscv_crypto_fu_issue.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : riscv_crypto_fu_issue
// Brief   : Issues one decoded op to a crypto FU, holds operands until ready,
//           and returns the result with rd tag on a writeback handshake.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module riscv_crypto_fu_issue #(
   parameter int XLEN    = 64,
   parameter int OPW     = 2,
   parameter int TIMEOUT = 16
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [OPW-1:0]  req_op,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   input  logic [4:0]      req_rd_addr,
   output logic            fu_valid,
   output logic [OPW-1:0]  fu_op,
   output logic [XLEN-1:0] fu_rs1,
   output logic [XLEN-1:0] fu_rs2,
   input  logic            fu_ready,
   input  logic [XLEN-1:0] fu_rd,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [XLEN-1:0] wb_data,
   output logic [4:0]      wb_rd_addr,
   output logic            wb_err
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] C_CNT_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          w_accept;
   logic          w_legal;
   logic          w_fu_done;
   logic          w_timeout;

   assign w_legal = $onehot(req_op);

   always_comb begin
      req_ready   = 1'b0;
      w_state_nxt = r_state;
      if (!g_reset && !flush) begin
         case (r_state)
            ST_IDLE: req_ready = 1'b1;
            ST_RESP: req_ready = wb_ready;
            default: req_ready = 1'b0;
         endcase
      end
      w_accept  = req_valid && req_ready;
      w_fu_done = (r_state == ST_ISSUE) && fu_ready;
      // fu_ready on the final counted cycle takes precedence over the timeout
      w_timeout = (r_state == ST_ISSUE) && !fu_ready && (r_cnt == C_CNT_MAX);
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = w_legal ? ST_ISSUE : ST_RESP;
         end
         ST_ISSUE: begin
            if (w_fu_done || w_timeout) w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (wb_ready) begin
               if (w_accept) w_state_nxt = w_legal ? ST_ISSUE : ST_RESP;
               else          w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (flush) w_state_nxt = ST_IDLE;
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         fu_valid   <= 1'b0;
         fu_op      <= '0;
         fu_rs1     <= '0;
         fu_rs2     <= '0;
         wb_valid   <= 1'b0;
         wb_data    <= '0;
         wb_rd_addr <= '0;
         wb_err     <= 1'b0;
         r_cnt      <= '0;
      end else begin
         fu_valid <= (w_state_nxt == ST_ISSUE);
         wb_valid <= (w_state_nxt == ST_RESP);
         if (w_state_nxt != ST_ISSUE) fu_op <= '0;
         if ((r_state == ST_ISSUE) && (r_cnt != C_CNT_MAX)) r_cnt <= r_cnt + CW'(1);
         // flush discards any result that would otherwise land this cycle
         if (!flush) begin
            if (w_accept) begin
               fu_rs1     <= req_rs1;
               fu_rs2     <= req_rs2;
               wb_rd_addr <= req_rd_addr;
               r_cnt      <= '0;
               if (w_legal) begin
                  fu_op <= req_op;
               end else begin
                  wb_data <= '0;
                  wb_err  <= 1'b1;
               end
            end else if (w_fu_done) begin
               wb_data <= fu_rd;
               wb_err  <= 1'b0;
            end else if (w_timeout) begin
               wb_data <= '0;
               wb_err  <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_crypto_fu_issue.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_riscv_crypto_fu_issue
// Brief   : Directed bench for riscv_crypto_fu_issue (64-bit and 32-bit builds).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_riscv_crypto_fu_issue;

   logic        g_clk = 1'b0;
   logic        g_reset, flush, req_valid, wb_ready, fu_auto, fu_force;
   logic [1:0]  req_op;
   logic [63:0] req_rs1, req_rs2;
   logic [4:0]  req_rd_addr;

   logic        req_ready, fu_valid, fu_ready, wb_valid, wb_err;
   logic [1:0]  fu_op;
   logic [63:0] fu_rs1, fu_rs2, fu_rd, wb_data;
   logic [4:0]  wb_rd_addr;

   logic        req_ready_32, fu_valid_32, fu_ready_32, wb_valid_32, wb_err_32;
   logic [1:0]  fu_op_32;
   logic [31:0] fu_rs1_32, fu_rs2_32, fu_rd_32, wb_data_32;
   logic [4:0]  wb_rd_addr_32;
   logic [63:0] t32;

   int checks = 0;
   int errors = 0;
   int n;
   logic seen;

   always #5 g_clk = ~g_clk;

   riscv_crypto_fu_issue #(.XLEN(64), .OPW(2), .TIMEOUT(4)) dut (
      .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd_addr(req_rd_addr),
      .fu_valid(fu_valid), .fu_op(fu_op), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2),
      .fu_ready(fu_ready), .fu_rd(fu_rd),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_rd_addr(wb_rd_addr), .wb_err(wb_err)
   );

   riscv_crypto_fu_issue #(.XLEN(32), .OPW(2), .TIMEOUT(4)) dut32 (
      .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready_32), .req_op(req_op),
      .req_rs1(req_rs1[31:0]), .req_rs2(req_rs2[31:0]), .req_rd_addr(req_rd_addr),
      .fu_valid(fu_valid_32), .fu_op(fu_op_32), .fu_rs1(fu_rs1_32), .fu_rs2(fu_rs2_32),
      .fu_ready(fu_ready_32), .fu_rd(fu_rd_32),
      .wb_valid(wb_valid_32), .wb_ready(wb_ready), .wb_data(wb_data_32),
      .wb_rd_addr(wb_rd_addr_32), .wb_err(wb_err_32)
   );

   // Reference xperm4/xperm8 acting as the FU
   function automatic logic [63:0] xperm(input logic [1:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input int xlen);
      logic [63:0] r;
      int idx;
      r = '0;
      if (op == 2'b10) begin
         for (int i = 0; i < xlen / 8; i++) begin
            idx = int'(b[i*8 +: 8]);
            if (idx < xlen / 8) r[i*8 +: 8] = a[idx*8 +: 8];
         end
      end else if (op == 2'b01) begin
         for (int i = 0; i < xlen / 4; i++) begin
            idx = int'(b[i*4 +: 4]);
            if (idx < xlen / 4) r[i*4 +: 4] = a[idx*4 +: 4];
         end
      end
      return r;
   endfunction

   always_comb begin
      fu_ready    = fu_auto ? fu_valid : fu_force;
      fu_ready_32 = fu_auto ? fu_valid_32 : fu_force;
      fu_rd       = xperm(fu_op, fu_rs1, fu_rs2, 64);
      t32         = xperm(fu_op_32, {32'b0, fu_rs1_32}, {32'b0, fu_rs2_32}, 32);
      fu_rd_32    = t32[31:0];
   end

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] op, input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic [4:0] rd);
      req_valid = 1'b1; req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd_addr = rd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      g_reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0;
      req_rs1 = '0; req_rs2 = '0; req_rd_addr = '0; wb_ready = 1'b1;
      fu_auto = 1'b1; fu_force = 1'b0;

      // Reset values
      tick();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_fu_valid", fu_valid, 0);
      chk("rst_fu_op", fu_op, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_data", wb_data, 0);
      g_reset = 1'b0;
      tick();
      chk("idle_req_ready", req_ready, 1);
      chk("idle_fu_rs1", fu_rs1, 0);

      // Single xperm8
      drive(2'b10, 64'h0001020304050607, 64'h0706050403020100, 5'd5);
      tick();
      req_valid = 1'b0;
      chk("x8_fu_valid", fu_valid, 1);
      chk("x8_fu_op", fu_op, 2'b10);
      chk("x8_req_ready", req_ready, 0);
      chk("x8_wb_valid_early", wb_valid, 0);
      tick();
      chk("x8_fu_valid_off", fu_valid, 0);
      chk("x8_wb_valid", wb_valid, 1);
      chk("x8_wb_data", wb_data, 64'h0001020304050607);
      chk("x8_wb_rd", wb_rd_addr, 5);
      chk("x8_wb_err", wb_err, 0);
      tick();
      chk("x8_idle", wb_valid, 0);

      // Writeback backpressure then back-to-back accept
      wb_ready = 1'b0;
      drive(2'b01, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 5'd9);
      tick();
      req_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_wb_valid", wb_valid, 1);
         chk("bp_wb_data", wb_data, 64'h0123456789ABCDEF);
         chk("bp_wb_rd", wb_rd_addr, 9);
         chk("bp_req_ready", req_ready, 0);
         tick();
      end
      wb_ready = 1'b1;
      drive(2'b10, 64'h1122334455667788, 64'h0, 5'd3);
      #1;
      chk("b2b_req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk("b2b_fu_valid", fu_valid, 1);
      chk("b2b_wb_valid", wb_valid, 0);
      chk("b2b_fu_rs1", fu_rs1, 64'h1122334455667788);
      tick();
      chk("b2b_wb_data", wb_data, 64'h8888888888888888);
      chk("b2b_wb_rd", wb_rd_addr, 3);
      tick();

      // Timeout with FU never ready
      fu_auto = 1'b0;
      drive(2'b01, 64'h0123456789ABCDEF, 64'h00000000000000F0, 5'd7);
      tick();
      req_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 10 && !wb_valid; i++) begin
         if (fu_valid) n++;
         tick();
      end
      chk("to_wb_valid", wb_valid, 1);
      chk("to_fu_cycles", 64'(n), 4);
      chk("to_wb_err", wb_err, 1);
      chk("to_wb_data", wb_data, 0);
      chk("to_wb_rd", wb_rd_addr, 7);
      tick();

      // FU ready on the last cycle before timeout wins
      drive(2'b01, 64'h0123456789ABCDEF, 64'h00000000000000F0, 5'd8);
      tick();
      req_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) begin
            chk("late_fu_valid", fu_valid, 1);
            fu_force = 1'b1;
         end
         tick();
      end
      fu_force = 1'b0;
      fu_auto = 1'b1;
      chk("late_wb_valid", wb_valid, 1);
      chk("late_wb_err", wb_err, 0);
      chk("late_wb_data", wb_data, 64'hFFFFFFFFFFFFFF0F);
      tick();

      // Illegal ops, back-to-back
      drive(2'b11, 64'h55, 64'h66, 5'd12);
      tick();
      chk("ill11_fu_valid", fu_valid, 0);
      chk("ill11_wb_valid", wb_valid, 1);
      chk("ill11_wb_err", wb_err, 1);
      chk("ill11_wb_data", wb_data, 0);
      chk("ill11_wb_rd", wb_rd_addr, 12);
      drive(2'b00, 64'h55, 64'h66, 5'd13);
      tick();
      req_valid = 1'b0;
      chk("ill00_fu_valid", fu_valid, 0);
      chk("ill00_wb_valid", wb_valid, 1);
      chk("ill00_wb_err", wb_err, 1);
      chk("ill00_wb_rd", wb_rd_addr, 13);
      tick();
      chk("ill_idle", wb_valid, 0);

      // Flush in ISSUE
      fu_auto = 1'b0;
      drive(2'b10, 64'h0001020304050607, 64'h0706050403020100, 5'd20);
      tick();
      req_valid = 1'b0;
      flush = 1'b1;
      #1;
      chk("fli_req_ready", req_ready, 0);
      tick();
      chk("fli_fu_valid", fu_valid, 0);
      chk("fli_wb_valid", wb_valid, 0);
      chk("fli_fu_op", fu_op, 0);
      flush = 1'b0;
      fu_auto = 1'b1;
      #1;
      chk("fli_req_ready_after", req_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (wb_valid) seen = 1'b1;
      end
      chk("fli_no_wb", seen, 0);

      // Flush in RESP, with a request offered in the flush cycle
      wb_ready = 1'b0;
      drive(2'b10, 64'h0001020304050607, 64'h0706050403020100, 5'd21);
      tick();
      req_valid = 1'b0;
      tick();
      chk("flr_wb_valid", wb_valid, 1);
      flush = 1'b1; wb_ready = 1'b1; req_valid = 1'b1;
      #1;
      chk("flr_req_ready", req_ready, 0);
      tick();
      chk("flr_wb_valid_off", wb_valid, 0);
      chk("flr_fu_valid_off", fu_valid, 0);
      flush = 1'b0; req_valid = 1'b0;
      #1;
      chk("flr_req_ready_after", req_ready, 1);

      // Reset mid-ISSUE
      fu_auto = 1'b0;
      drive(2'b01, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 5'd22);
      tick();
      req_valid = 1'b0;
      chk("rmi_fu_valid", fu_valid, 1);
      g_reset = 1'b1;
      tick();
      chk("rmi_req_ready", req_ready, 0);
      chk("rmi_fu_valid_off", fu_valid, 0);
      chk("rmi_fu_op", fu_op, 0);
      chk("rmi_fu_rs1", fu_rs1, 0);
      chk("rmi_fu_rs2", fu_rs2, 0);
      chk("rmi_wb_valid", wb_valid, 0);
      chk("rmi_wb_data", wb_data, 0);
      chk("rmi_wb_rd", wb_rd_addr, 0);
      chk("rmi_wb_err", wb_err, 0);
      chk("rmi32_fu_valid", fu_valid_32, 0);
      g_reset = 1'b0;
      fu_auto = 1'b1;
      #1;
      chk("rmi_req_ready_after", req_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (wb_valid || wb_valid_32) seen = 1'b1;
      end
      chk("rmi_no_wb", seen, 0);

      // xperm4 on the 32-bit build
      drive(2'b01, 64'h0000000076543210, 64'h0000000001234567, 5'd17);
      tick();
      req_valid = 1'b0;
      chk("x4_32_fu_valid", fu_valid_32, 1);
      chk("x4_32_fu_rs2", fu_rs2_32, 32'h01234567);
      tick();
      chk("x4_32_wb_valid", wb_valid_32, 1);
      chk("x4_32_wb_data", wb_data_32, 32'h01234567);
      chk("x4_32_wb_err", wb_err_32, 0);
      chk("x4_32_wb_rd", wb_rd_addr_32, 17);
      chk("x4_64_wb_data", wb_data, 64'h0000000001234567);
      tick();
      chk("x4_32_idle", wb_valid_32, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
